// File: rtl/ps2_pkg.sv
// Shared PS/2 frame constants, receiver FSM encoding and the frame
// acceptance rule used by the receiver.
package ps2_pkg;

  localparam int       FRAME_BITS = 11;    // start + 8 data + parity + stop
  localparam int       DATA_BITS  = 8;
  localparam logic     ODD_PARITY = 1'b1;  // data + parity must hold an odd count of ones

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  function automatic logic frame_good(input logic [DATA_BITS-1:0] data,
                                      input logic                 parity,
                                      input logic                 stop);
    return stop && ((^{data, parity}) == ODD_PARITY);
  endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// Pin and byte-stream bundle of the PS/2 receiver, with a driving side
// (device pins + consumer) and a receiving side.
interface ps2_rx_if;
  // rx_valid/rx_ready: a byte moves when both are high in the same clk cycle;
  // rx_valid never depends on rx_ready and rx_data is stable while
  // rx_valid is high and not yet accepted.
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overflow;

  modport master (output ps2_clk, ps2_data, rx_ready,
                  input  rx_data, rx_valid, frame_err, overflow);

  modport slave  (input  ps2_clk, ps2_data, rx_ready,
                  output rx_data, rx_valid, frame_err, overflow);
endinterface

// File: rtl/byte_fifo.sv
// Byte FIFO with a registered head output; DEPTH must be a power of two, >= 2.
// A push while full is accepted only when a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop_ok;
  logic          push_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= 8'h00;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // The head register holds its last value when a pop drains the FIFO.
      if (pop_ok) begin
        if (count > (AW+1)'(1)) dout <= mem[rd_ptr + AW'(1)];
        else if (push_ok)       dout <= din;
      end else if (push_ok && empty) begin
        dout <= din;
      end
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pin synchronizers, falling-edge detect,
// frame FSM with inactivity timeout, and a byte FIFO toward the consumer.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(DATA_BITS);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   data_s;
  logic                   clk_prev;
  logic                   fall;

  ps2_state_t           state, state_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic                 parity_bit, parity_n;
  logic [TW-1:0]        tmo_cnt, tmo_n;
  logic                 done;
  logic                 timeout_hit;
  logic                 good;

  logic                 push_q;
  logic [7:0]           push_byte;
  logic                 err_q;
  logic                 fifo_full;
  logic                 fifo_empty;

  // Synchronizers load the idle-high level in reset so release makes no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= SYNC_STAGES'({clk_sync, ps2_clk});
      data_sync <= SYNC_STAGES'({data_sync, ps2_data});
      clk_prev  <= clk_s;
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev && !clk_s;
  assign good   = frame_good(shift_reg, parity_bit, data_s);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tmo_cnt    <= '0;
      push_q     <= 1'b0;
      push_byte  <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift_reg  <= shift_n;
      parity_bit <= parity_n;
      tmo_cnt    <= tmo_n;
      push_q     <= done && good;
      push_byte  <= shift_reg;
      err_q      <= (done && !good) || timeout_hit;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift_reg;
    parity_n    = parity_bit;
    tmo_n       = tmo_cnt;
    done        = 1'b0;
    timeout_hit = 1'b0;

    if (state == IDLE || fall) tmo_n = '0;
    else                       tmo_n = tmo_cnt + TW'(1);

    case (state)
      IDLE: begin
        if (fall && !data_s) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_n   = {data_s, shift_reg[DATA_BITS-1:1]};
          bit_cnt_n = bit_cnt + BW'(1);
          if (bit_cnt == BW'(DATA_BITS - 1)) state_n = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          parity_n = data_s;
          state_n  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // A stalled device clock abandons the partial frame.
    if (state != IDLE && !fall && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      timeout_hit = 1'b1;
      state_n     = IDLE;
      tmo_n       = '0;
      shift_n     = '0;
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .din   (push_byte),
    .pop   (rx_ready),
    .dout  (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid  = !fifo_empty;
  assign frame_err = err_q;
  // push_q follows a good stop edge, so it never coincides with err_q.
  assign overflow  = push_q && fifo_full && !(rx_ready && rx_valid);

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: bit-banged PS/2 frames, expected-byte queue,
// pulse monitors for frame_err/overflow.
module tb_ps2_rx;
  import ps2_pkg::*;

  localparam int FIFO_DEPTH     = 4;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int SYNC_STAGES    = 2;
  localparam int HALF           = 10;

  logic clk;
  logic rst;

  ps2_rx_if bus ();

  ps2_rx #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (bus.ps2_clk),
    .ps2_data  (bus.ps2_data),
    .rx_data   (bus.rx_data),
    .rx_valid  (bus.rx_valid),
    .rx_ready  (bus.rx_ready),
    .frame_err (bus.frame_err),
    .overflow  (bus.overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int checks     = 0;
  int failures   = 0;
  int err_pulses = 0;
  int ovf_pulses = 0;
  int both_pulse = 0;

  always @(negedge clk) begin
    if (bus.frame_err) err_pulses++;
    if (bus.overflow)  ovf_pulses++;
    if (bus.frame_err && bus.overflow) both_pulse++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Sends the first nbits of {stop, parity, byte, start}; lat reports the
  // posedge index within the stop-bit low phase where rx_valid was first seen.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input int nbits, output int lat);
    logic [10:0] frm;
    frm = {stp, par, b, 1'b0};
    lat = 0;
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = frm[i];
      repeat (HALF) @(posedge clk);
      #1;
      bus.ps2_clk = 1'b0;
      for (int k = 1; k <= HALF; k++) begin
        @(posedge clk);
        #1;
        if (i == FRAME_BITS - 1 && lat == 0 && bus.rx_valid) lat = k;
      end
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
    repeat (2 * HALF) @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    check({tag, "_valid"}, 32'(bus.rx_valid), 32'd1);
    check({tag, "_data"},  32'(bus.rx_data),  32'(e));
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_ready = 1'b0;
  endtask

  logic [7:0] seq_b [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
  logic       seq_p [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    rst          = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    bus.rx_ready = 1'b0;
    idle_cycles(5);
    check("rst_valid",    32'(bus.rx_valid),  32'd0);
    check("rst_data",     32'(bus.rx_data),   32'h00);
    check("rst_err",      32'(bus.frame_err), 32'd0);
    check("rst_overflow", 32'(bus.overflow),  32'd0);
    rst = 1'b0;
    idle_cycles(5);

    // Single good byte; rx_valid rises 4 posedges after the stop-bit fall
    // (2 sync stages + edge register + push register).
    send_frame(8'h1C, 1'b0, 1'b1, FRAME_BITS, lat);
    exp_q.push_back(8'h1C);
    check("single_latency", 32'(lat), 32'd4);
    pop_check("single");
    check("single_drained", 32'(bus.rx_valid), 32'd0);
    check("single_data_hold", 32'(bus.rx_data), 32'h1C);
    check("single_no_err", 32'(err_pulses), 32'd0);

    // Two queued bytes, then two pops in order.
    send_frame(8'hF0, 1'b1, 1'b1, FRAME_BITS, lat);
    exp_q.push_back(8'hF0);
    send_frame(8'h1C, 1'b0, 1'b1, FRAME_BITS, lat);
    exp_q.push_back(8'h1C);
    pop_check("pair0");
    pop_check("pair1");
    check("pair_drained", 32'(bus.rx_valid), 32'd0);
    check("pair_no_err", 32'(err_pulses), 32'd0);

    // Parity error.
    send_frame(8'h1C, 1'b1, 1'b1, FRAME_BITS, lat);
    check("parity_err", 32'(err_pulses), 32'd1);
    check("parity_valid", 32'(bus.rx_valid), 32'd0);

    // Stop-bit error.
    send_frame(8'h1C, 1'b0, 1'b0, FRAME_BITS, lat);
    check("stop_err", 32'(err_pulses), 32'd2);
    check("stop_valid", 32'(bus.rx_valid), 32'd0);

    // Timeout after start + 4 data bits, then recovery.
    send_frame(8'h1C, 1'b0, 1'b1, 5, lat);
    idle_cycles(TIMEOUT_CYCLES / 2);
    check("timeout_early", 32'(err_pulses), 32'd2);
    idle_cycles(TIMEOUT_CYCLES);
    check("timeout_err", 32'(err_pulses), 32'd3);
    check("timeout_valid", 32'(bus.rx_valid), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b1, FRAME_BITS, lat);
    exp_q.push_back(8'h1C);
    pop_check("after_timeout");
    check("after_timeout_err", 32'(err_pulses), 32'd3);

    // Overflow: five good bytes into a four-deep FIFO.
    for (int i = 0; i < 5; i++) begin
      send_frame(seq_b[i], seq_p[i], 1'b1, FRAME_BITS, lat);
      if (i < FIFO_DEPTH) exp_q.push_back(seq_b[i]);
      if (i == 3) check("ovf_before_fifth", 32'(ovf_pulses), 32'd0);
    end
    check("ovf_count", 32'(ovf_pulses), 32'd1);
    check("ovf_no_err", 32'(err_pulses), 32'd3);
    for (int i = 0; i < FIFO_DEPTH; i++) pop_check($sformatf("ovf_pop%0d", i));
    check("ovf_drained", 32'(bus.rx_valid), 32'd0);

    // Reset after the 5th data bit abandons silently; next frame resyncs.
    send_frame(8'hAA, 1'b1, 1'b1, 6, lat);
    rst = 1'b1;
    idle_cycles(3);
    rst = 1'b0;
    idle_cycles(TIMEOUT_CYCLES + 20);
    check("midrst_valid", 32'(bus.rx_valid), 32'd0);
    check("midrst_err", 32'(err_pulses), 32'd3);
    send_frame(8'hF0, 1'b1, 1'b1, FRAME_BITS, lat);
    exp_q.push_back(8'hF0);
    pop_check("after_reset");

    check("final_err_total", 32'(err_pulses), 32'd3);
    check("final_ovf_total", 32'(ovf_pulses), 32'd1);
    check("err_ovf_exclusive", 32'(both_pulse), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of received bytes buffered; it must be a power of two.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, giving the clk cycles without a ps2_clk falling edge before a partial frame is abandoned (1 ms at 50 MHz).
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, giving the flip-flop depth of each pin synchronizer.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port ps2_clk, input, 1 bit: the asynchronous PS/2 device clock, sampled only and never driven.
REQ-007 The block SHALL have port ps2_data, input, 1 bit: the asynchronous PS/2 device data, sampled only and never driven.
REQ-008 The block SHALL have port rx_data, output, 8 bits: the FIFO head byte.
REQ-009 The block SHALL have port rx_valid, output, 1 bit: high when the FIFO is non-empty.
REQ-010 The block SHALL have port rx_ready, input, 1 bit: the consumer accepts the head byte.
REQ-011 The block SHALL have port frame_err, output, 1 bit: a one-cycle pulse on a parity, stop or timeout error.
REQ-012 The block SHALL have port overflow, output, 1 bit: a one-cycle pulse when a good frame is dropped because the FIFO is full.

Function
REQ-013 Both pins SHALL pass through SYNC_STAGES flip-flops; a falling edge is detected as sync value 0 in the current cycle and 1 in the previous cycle, so detection lags the pin by SYNC_STAGES+1 cycles.
REQ-014 Data SHALL be sampled only in the cycle a falling edge is detected, using the synchronized ps2_data.
REQ-015 The FSM SHALL have the states IDLE, DATA, PARITY and STOP.
REQ-016 In IDLE, an edge with data 0 SHALL go to DATA and clear the bit counter; an edge with data 1 SHALL be ignored and the FSM stays in IDLE.
REQ-017 In DATA, each edge SHALL shift the bit in LSB-first; after the 8th bit the FSM goes to PARITY.
REQ-018 In PARITY, an edge SHALL capture the parity bit and go to STOP.
REQ-019 In STOP, an edge SHALL complete the frame and return to IDLE.
REQ-020 A frame SHALL be good when the stop bit is 1 and the 8 data bits plus the parity bit contain an odd number of ones.
REQ-021 A good frame SHALL be pushed to the FIFO the cycle after the stop edge, with rx_valid high the following cycle.
REQ-022 A bad frame SHALL pulse frame_err for one cycle and SHALL NOT be pushed.
REQ-023 The timeout counter SHALL run outside IDLE and clear on every detected edge.
REQ-024 When the timeout counter reaches TIMEOUT_CYCLES-1, the FSM SHALL return to IDLE, pulse frame_err and discard the partial byte.
REQ-025 In IDLE the timeout counter SHALL be held at 0.
REQ-026 A pop SHALL occur in any cycle where rx_valid and rx_ready are both high.
REQ-027 rx_data SHALL present the next entry, or its previous value if the FIFO is then empty, in the cycle after a pop.
REQ-028 When the FIFO is full, a push with no simultaneous pop SHALL drop the byte and pulse overflow.
REQ-029 When the FIFO is full, a push with a simultaneous pop SHALL be accepted, the count stays full and no overflow pulse occurs.
REQ-030 When the FIFO is empty, rx_ready SHALL be ignored and there is no underflow.
REQ-031 A simultaneous push and pop at non-full occupancy SHALL leave the count unchanged.
REQ-032 Read and write pointers SHALL wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits wide.
REQ-033 A frame_err pulse and an overflow pulse SHALL never occur in the same cycle.

Reset
REQ-034 While rst is high at a clk edge, the FSM SHALL go to IDLE and the bit counter, timeout counter, FIFO pointers and count SHALL clear.
REQ-035 While rst is high at a clk edge, rx_data SHALL be set to 0x00 and rx_valid, frame_err and overflow to 0.
REQ-036 While rst is high at a clk edge, the synchronizer flip-flops SHALL be loaded with 1, the idle-high bus level, so that no false edge occurs on release.
REQ-037 Reset asserted mid-frame SHALL abandon the frame without an error pulse.
REQ-038 After reset the block SHALL resynchronize on the next start bit.

Structure
REQ-039 The PS/2 frame constants (11 bits per frame, 8 data bits, odd parity) and the FSM state encoding SHALL live in a shared package, ps2_pkg.
REQ-040 The FIFO SHALL be a separate sub-module, byte_fifo, parameterized by depth, with push/pop/full/empty ports and synchronous reset.
REQ-041 The synchronizer, edge detect, FSM and timeout logic SHALL stay in ps2_rx.

Verification
REQ-042 A frame for byte 0x1C with parity 0 and stop 1 SHALL produce rx_valid=1 and rx_data=0x1C, with rx_ready=1 popping it and frame_err never pulsing.
REQ-043 The sequence 0xF0 (parity 1) followed by 0x1C, sent with rx_ready=0, SHALL leave both queued, and two pops SHALL return 0xF0 then 0x1C.
REQ-044 A 0x1C frame with parity 1 SHALL pulse frame_err once and keep rx_valid=0.
REQ-045 A 0x1C frame with a stop bit of 0 SHALL pulse frame_err once and keep rx_valid=0.
REQ-046 Stopping the device clock after 4 data bits SHALL pulse frame_err after TIMEOUT_CYCLES, and a following full 0x1C frame SHALL be received correctly.
REQ-047 Five good frames 0x01..0x05 with rx_ready=0 and FIFO_DEPTH=4 SHALL pulse overflow once on 0x05, and pops SHALL return 0x01..0x04.
REQ-048 Asserting rst after the 5th data bit SHALL keep rx_valid=0 and frame_err=0, and the next 0xF0 frame SHALL be received correctly.
